bit_byte_ram: RTL and testbench



---
 rtl/bit_byte_ram_pkg.sv | 45 ++++
 rtl/bit_addr_decode.sv | 30 +++
 rtl/bit_byte_ram.sv | 182 ++++++++++++++++++
 tb/tb_bit_byte_ram.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/bit_byte_ram_pkg.sv
// Shared op codes, FSM encoding and bit-modify helpers for the bit/byte data RAM.
// Latency: none, this file holds definitions only.
// Backpressure: none.
package bit_byte_ram_pkg;

  // Request op codes; 3'b011 is reserved and completes with an error
  typedef enum logic [2:0] {
    OP_BYTE_RD = 3'b000,
    OP_BYTE_WR = 3'b001,
    OP_BIT_CPL = 3'b010,
    OP_BIT_RD  = 3'b100,
    OP_BIT_WR  = 3'b101,
    OP_BIT_SET = 3'b110,
    OP_BIT_CLR = 3'b111
  } op_e;

  localparam logic [2:0] OP_RSVD = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Bit ops are the whole upper half of the op space plus CPL
  function automatic logic is_bit_op(input logic [2:0] op);
    return op[2] | (op == OP_BIT_CPL);
  endfunction

  // Value the selected bit takes after a bit-modify op; the caller merges it
  // into the previously read byte so the other bits are preserved
  function automatic logic new_bit(input logic [2:0] op, input logic bin, input logic old_bit);
    logic v;
    case (op)
      OP_BIT_WR:  v = bin;
      OP_BIT_SET: v = 1'b1;
      OP_BIT_CLR: v = 1'b0;
      OP_BIT_CPL: v = ~old_bit;
      default:    v = old_bit;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/bit_addr_decode.sv
// Maps a boolean-processor bit address onto a byte address and bit index in the bit window.
// Latency: purely combinational.
// Backpressure: none.
module bit_addr_decode #(
  parameter int DWIDTH     = 8,
  parameter int ADDRWIDTH  = 7,
  parameter int BITBASE    = 32,
  parameter int BITBYTES   = 16,
  parameter int BADDRWIDTH = 7
) (
  input  logic [BADDRWIDTH-1:0]     baddr,
  output logic [ADDRWIDTH-1:0]      byte_addr,
  output logic [$clog2(DWIDTH)-1:0] bit_idx,
  output logic                      out_of_range
);

  localparam int IDXW  = $clog2(DWIDTH);
  localparam int NBITS = BITBYTES * DWIDTH;

  logic [BADDRWIDTH-1:0] byte_off;

  // DWIDTH is a power of two, so divide/modulo reduce to a shift and a slice
  always_comb begin
    byte_off     = baddr >> IDXW;
    bit_idx      = baddr[IDXW-1:0];
    byte_addr    = ADDRWIDTH'(BITBASE) + ADDRWIDTH'(byte_off);
    out_of_range = (32'(baddr) >= 32'(NBITS));
  end

endmodule

// File: rtl/bit_byte_ram.sv
// Byte- and bit-addressable data RAM; bit writes run as internal read-modify-write.
// Latency: accept to ack 2 cycles (byte rd/wr, bit rd), 3 (bit modify), 1 (reserved op).
// Backpressure: one request at a time; CS is only sampled in IDLE, busy marks RD/WR.
module bit_byte_ram
  import bit_byte_ram_pkg::*;
#(
  parameter int DWIDTH     = 8,
  parameter int ADDRWIDTH  = 7,
  parameter int BITBASE    = 32,
  parameter int BITBYTES   = 16,
  parameter int BADDRWIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  CS,
  input  logic [2:0]            op,
  input  logic [ADDRWIDTH-1:0]  addr,
  input  logic [BADDRWIDTH-1:0] baddr,
  input  logic [DWIDTH-1:0]     din,
  input  logic                  bin,
  output logic [DWIDTH-1:0]     dout,
  output logic                  bout,
  output logic                  busy,
  output logic                  ack,
  output logic                  err
);

  localparam int DEPTH = 2 ** ADDRWIDTH;
  localparam int IDXW  = $clog2(DWIDTH);

  // Everything captured at accept; the request inputs are ignored afterwards
  typedef struct packed {
    logic [2:0]            op;
    logic [ADDRWIDTH-1:0]  addr;
    logic [BADDRWIDTH-1:0] baddr;
    logic [DWIDTH-1:0]     din;
    logic                  bin;
  } req_t;

  state_e                state_q, state_d;
  req_t                  req_q, req_d;
  logic [DWIDTH-1:0]     tmp_q, tmp_d;
  logic [DWIDTH-1:0]     dout_q, dout_d;
  logic                  bout_q, bout_d;
  logic                  busy_q, busy_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;

  logic [DWIDTH-1:0]     mem_q [DEPTH];
  logic                  wr_en;
  logic [ADDRWIDTH-1:0]  wr_addr;
  logic [DWIDTH-1:0]     wr_dat;

  logic [ADDRWIDTH-1:0]  dec_byte;
  logic [IDXW-1:0]       dec_idx;
  logic                  dec_oor;

  logic [ADDRWIDTH-1:0]  rd_addr;
  logic [DWIDTH-1:0]     rd_byte;
  logic [DWIDTH-1:0]     bit_mask;
  logic [DWIDTH-1:0]     mod_byte;
  logic                  new_val;

  bit_addr_decode #(
    .DWIDTH     (DWIDTH),
    .ADDRWIDTH  (ADDRWIDTH),
    .BITBASE    (BITBASE),
    .BITBYTES   (BITBYTES),
    .BADDRWIDTH (BADDRWIDTH)
  ) u_dec (
    .baddr        (req_q.baddr),
    .byte_addr    (dec_byte),
    .bit_idx      (dec_idx),
    .out_of_range (dec_oor)
  );

  // Datapath: target byte select, array read and the merged byte for bit writes
  always_comb begin
    rd_addr  = is_bit_op(req_q.op) ? dec_byte : req_q.addr;
    rd_byte  = mem_q[rd_addr];
    bit_mask = DWIDTH'(1) << dec_idx;
    new_val  = new_bit(req_q.op, req_q.bin, tmp_q[dec_idx]);
    mod_byte = new_val ? (tmp_q | bit_mask) : (tmp_q & ~bit_mask);
  end

  // FSM next state, result capture and array write control
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    tmp_d   = tmp_q;
    dout_d  = dout_q;
    bout_d  = bout_q;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = req_q.addr;
    wr_dat  = req_q.din;
    case (state_q)
      ST_IDLE: begin
        if (!CS) begin
          req_d = '{op, addr, baddr, din, bin};
          if (op == OP_RSVD) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else if (op == OP_BYTE_WR) begin
            state_d = ST_WR;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      ST_RD: begin
        tmp_d = rd_byte;
        if (!is_bit_op(req_q.op)) begin
          dout_d  = rd_byte;
          state_d = ST_DONE;
        end else if (dec_oor) begin
          // Out-of-window bit: report error, never touch the array
          bout_d  = 1'b0;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          bout_d  = rd_byte[dec_idx];
          state_d = (req_q.op == OP_BIT_RD) ? ST_DONE : ST_WR;
        end
      end
      ST_WR: begin
        wr_en   = 1'b1;
        state_d = ST_DONE;
        if (is_bit_op(req_q.op)) begin
          wr_addr = dec_byte;
          wr_dat  = mod_byte;
        end
      end
      ST_DONE: begin
        // CS is deliberately not sampled here; a held request is taken in IDLE
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_RD) || (state_d == ST_WR);
    ack_d  = (state_d == ST_DONE);
  end

  // Control and output registers; reset aborts any request in flight
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      tmp_q   <= '0;
      dout_q  <= '0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      tmp_q   <= tmp_d;
      dout_q  <= dout_d;
      bout_q  <= bout_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  // Storage array: cleared by reset, single write port used in WR only
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
    end else if (wr_en) begin
      mem_q[wr_addr] <= wr_dat;
    end
  end

  assign dout = dout_q;
  assign bout = bout_q;
  assign busy = busy_q;
  assign ack  = ack_q;
  assign err  = err_q;

endmodule

// File: tb/tb_bit_byte_ram.sv
// Self-checking bench for bit_byte_ram: scoreboard of predicted completions.
// Latency: expected ack cycle is carried in each scoreboard entry.
// Backpressure: bench issues one request at a time except the held-CS sequence.
module tb_bit_byte_ram;
  import bit_byte_ram_pkg::*;

  localparam int DW  = 8;
  localparam int AW  = 7;
  localparam int BAW = 8;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b0;
  logic           CS    = 1'b1;
  logic [2:0]     op    = '0;
  logic [AW-1:0]  addr  = '0;
  logic [BAW-1:0] baddr = '0;
  logic [DW-1:0]  din   = '0;
  logic           bin   = 1'b0;
  logic [DW-1:0]  dout;
  logic           bout, busy, ack, err;

  always #5 clk = ~clk;

  bit_byte_ram #(
    .DWIDTH(DW), .ADDRWIDTH(AW), .BITBASE(32), .BITBYTES(16), .BADDRWIDTH(BAW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .CS(CS), .op(op), .addr(addr), .baddr(baddr),
    .din(din), .bin(bin), .dout(dout), .bout(bout), .busy(busy), .ack(ack), .err(err)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // Count state-changing (falling) edges; read only on rising edges
  always @(negedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  typedef struct {
    string      tag;
    logic [7:0] dout;
    logic       bout;
    logic       err;
    int         ack_cyc;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] mdl [128];
  logic [7:0] m_dout = '0;
  logic       m_bout = 1'b0;

  // Reference model: updates shadow memory and returns the expected completion
  function automatic exp_t predict(input string tag, input logic [2:0] o, input logic [6:0] a,
                                   input logic [7:0] ba, input logic [7:0] d, input logic b,
                                   input int acc);
    exp_t e;
    int   lat, by, ix;
    logic old;
    e.tag = tag;
    e.err = 1'b0;
    lat   = 2;
    case (o)
      3'b000: m_dout = mdl[a];
      3'b001: mdl[a] = d;
      3'b011: begin e.err = 1'b1; lat = 1; end
      default: begin
        if (ba >= 8'd128) begin
          e.err  = 1'b1;
          m_bout = 1'b0;
        end else begin
          by     = 32 + int'(ba) / 8;
          ix     = int'(ba) % 8;
          old    = mdl[by][ix];
          m_bout = old;
          if (o != 3'b100) begin
            lat = 3;
            case (o)
              3'b101:  mdl[by][ix] = b;
              3'b110:  mdl[by][ix] = 1'b1;
              3'b111:  mdl[by][ix] = 1'b0;
              default: mdl[by][ix] = ~old;
            endcase
          end
        end
      end
    endcase
    e.dout    = m_dout;
    e.bout    = m_bout;
    e.ack_cyc = acc + lat - 1;
    return e;
  endfunction

  // Completion monitor: every ack pops one prediction
  logic ack_prev = 1'b0;
  always @(posedge clk) begin : mon
    exp_t e;
    if (ack) begin
      check_val("ack_width", 32'(ack_prev), 0);
      check_val("sb_empty_on_ack", 32'(sbq.size() == 0), 0);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        check_val({e.tag, ".dout"}, 32'(dout), 32'(e.dout));
        check_val({e.tag, ".bout"}, 32'(bout), 32'(e.bout));
        check_val({e.tag, ".err"}, 32'(err), 32'(e.err));
        check_val({e.tag, ".ack_cyc"}, cyc, e.ack_cyc);
        check_val({e.tag, ".busy_at_ack"}, 32'(busy), 0);
      end
    end
    ack_prev = ack;
  end

  task automatic wait_ack(input string tag);
    bit got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      @(posedge clk);
      if (ack) got = 1'b1;
      else check_val({tag, ".busy"}, 32'(busy), 1);
    end
    if (!got) check_val({tag, ".ack_timeout"}, 32'(ack), 1);
  endtask

  task automatic req(input string tag, input logic [2:0] o, input logic [6:0] a,
                     input logic [7:0] ba, input logic [7:0] d, input logic b);
    @(posedge clk); #1;
    CS = 1'b0; op = o; addr = a; baddr = ba; din = d; bin = b;
    sbq.push_back(predict(tag, o, a, ba, d, b, cyc + 1));
    @(negedge clk); #1;
    CS = 1'b1;
    wait_ack(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a0, a1;
    for (int i = 0; i < 128; i++) mdl[i] = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_val("rst.dout", 32'(dout), 0);
    check_val("rst.bout", 32'(bout), 0);
    check_val("rst.busy", 32'(busy), 0);
    check_val("rst.ack",  32'(ack), 0);
    check_val("rst.err",  32'(err), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed sequence around byte 0x21
    req("rd21",   OP_BYTE_RD, 7'h21, 8'h00, 8'h00, 1'b0);
    req("wr21",   OP_BYTE_WR, 7'h21, 8'h00, 8'hA5, 1'b0);
    req("brd0b",  OP_BIT_RD,  7'h00, 8'h0B, 8'h00, 1'b0);
    req("brd08",  OP_BIT_RD,  7'h00, 8'h08, 8'h00, 1'b0);
    req("set0b",  OP_BIT_SET, 7'h00, 8'h0B, 8'h00, 1'b0);
    req("rd21b",  OP_BYTE_RD, 7'h21, 8'h00, 8'h00, 1'b0);
    req("cpl08",  OP_BIT_CPL, 7'h00, 8'h08, 8'h00, 1'b0);
    req("rd21c",  OP_BYTE_RD, 7'h21, 8'h00, 8'h00, 1'b0);
    check_val("mdl21_sanity", 32'(dout), 32'h0000_00AC);

    // Window edges, out-of-range and reserved op
    req("wr7f",   OP_BIT_WR,  7'h00, 8'h7F, 8'h00, 1'b1);
    req("clr00",  OP_BIT_CLR, 7'h00, 8'h00, 8'h00, 1'b0);
    req("rd2f",   OP_BYTE_RD, 7'h2F, 8'h00, 8'h00, 1'b0);
    req("oor80",  OP_BIT_WR,  7'h00, 8'h80, 8'h00, 1'b1);
    req("oorff",  OP_BIT_SET, 7'h00, 8'hFF, 8'h00, 1'b0);
    req("rsvd",   3'b011,     7'h21, 8'h0B, 8'hFF, 1'b1);

    // Random mix, weighted into the bit window
    for (int i = 0; i < 60; i++) begin
      logic [6:0] ra;
      ra = ($urandom_range(0, 1) == 0) ? 7'(32 + $urandom_range(0, 15)) : 7'($urandom_range(0, 127));
      req("rnd", 3'($urandom_range(0, 7)), ra, 8'($urandom_range(0, 143)),
          8'($urandom), 1'($urandom));
    end

    // Sweep the bit window against the model
    for (int i = 32; i < 48; i++) req("sweep", OP_BYTE_RD, 7'(i), 8'h00, 8'h00, 1'b0);

    // CS held low across two requests: second taken only in the IDLE after DONE
    @(posedge clk); #1;
    CS = 1'b0; op = OP_BIT_SET; addr = 7'h00; baddr = 8'h0C; din = 8'h00; bin = 1'b0;
    a0 = cyc + 1;
    sbq.push_back(predict("b2b0", OP_BIT_SET, 7'h00, 8'h0C, 8'h00, 1'b0, a0));
    @(negedge clk); #1;
    op = OP_BYTE_RD; addr = 7'h21;
    a1 = a0 + 3 + 1;
    sbq.push_back(predict("b2b1", OP_BYTE_RD, 7'h21, 8'h00, 8'h00, 1'b0, a1));
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      check_val("b2b.busy", 32'(busy), (i < 2) ? 1 : 0);
      if (i == 3) check_val("b2b.idle_ack", 32'(ack), 0);
    end
    @(negedge clk); #1;
    CS = 1'b1;
    wait_ack("b2b1");

    // Reset while a bit modify on byte 0x2F sits in WR
    req("wr2f", OP_BYTE_WR, 7'h2F, 8'h00, 8'h5A, 1'b0);
    @(posedge clk); #1;
    CS = 1'b0; op = OP_BIT_SET; baddr = 8'h7A;
    @(negedge clk); #1;
    CS = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    check_val("abort.busy_wr", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check_val("abort.busy", 32'(busy), 0);
    check_val("abort.ack",  32'(ack), 0);
    check_val("abort.dout", 32'(dout), 0);
    for (int i = 0; i < 128; i++) mdl[i] = '0;
    m_dout = '0;
    m_bout = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    req("rst_rd2f", OP_BYTE_RD, 7'h2F, 8'h00, 8'h00, 1'b0);
    req("rst_rd21", OP_BYTE_RD, 7'h21, 8'h00, 8'h00, 1'b0);
    req("rst_brd",  OP_BIT_RD,  7'h00, 8'h7A, 8'h00, 1'b0);

    repeat (3) @(posedge clk);
    check_val("sb_drained", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
